// File: rtl/us_cmd_sched_pkg.sv
// rtl/us_cmd_sched_pkg.sv - shared upstream command entry layout, type codes and len helpers
package us_cmd_sched_pkg;

    // Command type codes in entry bits [63:62]
    localparam logic [1:0] US_CMD_CPL  = 2'b00;
    localparam logic [1:0] US_CMD_CPLD = 2'b01;
    localparam logic [1:0] US_CMD_WR32 = 2'b10;
    localparam logic [1:0] US_CMD_INV  = 2'b11;

    // Entry field bit positions
    localparam int ENTRY_TYPE_HI = 63;
    localparam int ENTRY_TYPE_LO = 62;
    localparam int ENTRY_LEN_HI  = 61;
    localparam int ENTRY_LEN_LO  = 57;
    localparam int ENTRY_ID_HI   = 56;
    localparam int ENTRY_ID_LO   = 55;
    localparam int ENTRY_ADDR_HI = 31;

    // Completion fields {tc,td,ep,attr,len,rid,tag,be,addr[7:0]} occupy entry [54:0]
    localparam int CPL_FIELDS_W = 55;
    typedef logic [CPL_FIELDS_W-1:0] cpl_fields_t;

    // Accepted len exponent range (4 B .. 4 KB)
    localparam int LEN_MIN = 2;
    localparam int LEN_MAX = 12;

    // Byte counters are 13 bits wide so a full 4 KB command fits
    localparam int REM_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_CPL_REQ,
        ST_WR_CALC,
        ST_WR_REQ,
        ST_DONE
    } us_sched_state_t;

    // Clamp the len exponent into range and convert to a byte count
    function automatic logic [REM_W-1:0] len_to_bytes(input logic [4:0] len);
        logic [4:0] l;
        if (len < 5'(LEN_MIN)) begin
            l = 5'(LEN_MIN);
        end else if (len > 5'(LEN_MAX)) begin
            l = 5'(LEN_MAX);
        end else begin
            l = len;
        end
        return 13'd1 << l;
    endfunction

endpackage

// File: rtl/us_cmd_sched_wr_chunker.sv
// rtl/us_cmd_sched_wr_chunker.sv - min of remaining bytes, max payload and distance to next 4 KB boundary
module us_wr_chunker
    import us_cmd_sched_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 128
) (
    input  logic [REM_W-1:0] remaining,
    input  logic [11:0]      addr_low,
    output logic [REM_W-1:0] chunk,
    output logic             last
);

    localparam logic [REM_W-1:0] MPS = REM_W'(MAX_PAYLOAD_BYTES);

    logic [REM_W-1:0] dist_4k;
    logic [REM_W-1:0] lim;

    // Pick the smallest of the three limits; last when it consumes everything left
    always_comb begin
        dist_4k = 13'd4096 - {1'b0, addr_low};
        lim     = (remaining < MPS) ? remaining : MPS;
        chunk   = (dist_4k < lim) ? dist_4k : lim;
        last    = (chunk == remaining);
    end

endmodule

// File: rtl/us_cmd_sched.sv
// rtl/us_cmd_sched.sv - upstream command scheduler: FIFO pop, completion dispatch, WR32 TLP chunking
module us_cmd_sched
    import us_cmd_sched_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fifo_empty_i,
    input  logic [127:0] fifo_dout_i,
    output logic         fifo_rd_en_o,
    output logic         tx_cpl_req_o,
    output logic         tx_cpl_with_data_o,
    output logic [54:0]  tx_cpl_fields_o,
    input  logic         tx_cpl_done_i,
    output logic         tx_wr_req_o,
    output logic [31:0]  tx_wr_addr_o,
    output logic [9:0]   tx_wr_len_dw_o,
    output logic         tx_wr_last_o,
    input  logic         tx_wr_ack_i,
    output logic         cmd_compl_o,
    output logic [1:0]   cmd_id_o,
    output logic         busy_o
);

    us_sched_state_t  state;
    logic [31:0]      addr_q;
    logic [REM_W-1:0] remaining_q;
    logic [REM_W-1:0] chunk_q;
    logic [1:0]       id_q;

    logic [REM_W-1:0] chunk;
    logic             chunk_last;

    logic [1:0]       entry_type;
    logic             unused_hi;

    assign entry_type = fifo_dout_i[ENTRY_TYPE_HI:ENTRY_TYPE_LO];
    assign unused_hi  = ^fifo_dout_i[127:64];
    assign busy_o     = (state != ST_IDLE);

    us_wr_chunker #(
        .MAX_PAYLOAD_BYTES(MAX_PAYLOAD_BYTES)
    ) u_chunker (
        .remaining(remaining_q),
        .addr_low (addr_q[11:0]),
        .chunk    (chunk),
        .last     (chunk_last)
    );

    // Command FSM: pop one entry, dispatch it, and hold each request until the TX engine responds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            addr_q             <= '0;
            remaining_q        <= '0;
            chunk_q            <= '0;
            id_q               <= '0;
            fifo_rd_en_o       <= 1'b0;
            tx_cpl_req_o       <= 1'b0;
            tx_cpl_with_data_o <= 1'b0;
            tx_cpl_fields_o    <= '0;
            tx_wr_req_o        <= 1'b0;
            tx_wr_addr_o       <= '0;
            tx_wr_len_dw_o     <= '0;
            tx_wr_last_o       <= 1'b0;
            cmd_compl_o        <= 1'b0;
            cmd_id_o           <= '0;
        end else begin
            fifo_rd_en_o <= 1'b0;
            cmd_compl_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty_i) begin
                        fifo_rd_en_o <= 1'b1;
                        state        <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    id_q        <= fifo_dout_i[ENTRY_ID_HI:ENTRY_ID_LO];
                    addr_q      <= {fifo_dout_i[ENTRY_ADDR_HI:2], 2'b00};
                    remaining_q <= len_to_bytes(fifo_dout_i[ENTRY_LEN_HI:ENTRY_LEN_LO]);
                    case (entry_type)
                        US_CMD_CPL, US_CMD_CPLD: begin
                            tx_cpl_fields_o    <= fifo_dout_i[CPL_FIELDS_W-1:0];
                            tx_cpl_with_data_o <= (entry_type == US_CMD_CPLD);
                            tx_cpl_req_o       <= 1'b1;
                            state              <= ST_CPL_REQ;
                        end
                        US_CMD_WR32: begin
                            state <= ST_WR_CALC;
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
                ST_CPL_REQ: begin
                    if (tx_cpl_done_i) begin
                        tx_cpl_req_o <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_WR_CALC: begin
                    tx_wr_addr_o   <= addr_q;
                    tx_wr_len_dw_o <= chunk[11:2];
                    tx_wr_last_o   <= chunk_last;
                    chunk_q        <= chunk;
                    tx_wr_req_o    <= 1'b1;
                    state          <= ST_WR_REQ;
                end
                ST_WR_REQ: begin
                    if (tx_wr_ack_i) begin
                        tx_wr_req_o <= 1'b0;
                        addr_q      <= addr_q + {19'd0, chunk_q};
                        remaining_q <= remaining_q - chunk_q;
                        if (tx_wr_last_o) begin
                            cmd_compl_o <= 1'b1;
                            cmd_id_o    <= id_q;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_WR_CALC;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_us_cmd_sched.sv
// tb/tb_us_cmd_sched.sv - randomized self-checking bench for us_cmd_sched against a byte-range model
module tb_us_cmd_sched;

    localparam int MPS = 128;
    localparam int N   = 4096;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty_i;
    logic [127:0] fifo_dout_i = '0;
    logic         fifo_rd_en_o;
    logic         tx_cpl_req_o;
    logic         tx_cpl_with_data_o;
    logic [54:0]  tx_cpl_fields_o;
    logic         tx_cpl_done_i = 1'b0;
    logic         tx_wr_req_o;
    logic [31:0]  tx_wr_addr_o;
    logic [9:0]   tx_wr_len_dw_o;
    logic         tx_wr_last_o;
    logic         tx_wr_ack_i = 1'b0;
    logic         cmd_compl_o;
    logic [1:0]   cmd_id_o;
    logic         busy_o;

    always #5 clk = ~clk;

    us_cmd_sched #(.MAX_PAYLOAD_BYTES(MPS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fifo_empty_i      (fifo_empty_i),
        .fifo_dout_i       (fifo_dout_i),
        .fifo_rd_en_o      (fifo_rd_en_o),
        .tx_cpl_req_o      (tx_cpl_req_o),
        .tx_cpl_with_data_o(tx_cpl_with_data_o),
        .tx_cpl_fields_o   (tx_cpl_fields_o),
        .tx_cpl_done_i     (tx_cpl_done_i),
        .tx_wr_req_o       (tx_wr_req_o),
        .tx_wr_addr_o      (tx_wr_addr_o),
        .tx_wr_len_dw_o    (tx_wr_len_dw_o),
        .tx_wr_last_o      (tx_wr_last_o),
        .tx_wr_ack_i       (tx_wr_ack_i),
        .cmd_compl_o       (cmd_compl_o),
        .cmd_id_o          (cmd_id_o),
        .busy_o            (busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Upstream FIFO contents: pushed by the stimulus, popped by the monitor
    logic [127:0] mem [N];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [127:0] popped = '0;
    assign fifo_empty_i = (wr_ptr == rd_ptr);

    // Expected TLPs, completions and cmd ids
    logic [31:0] e_addr [N];
    int          e_dw   [N];
    bit          e_last [N];
    int tw = 0, tr = 0;
    bit          e_cwd  [N];
    logic [54:0] e_cf   [N];
    int cw = 0, cr = 0;
    logic [1:0]  e_id   [N];
    int iw = 0, ir = 0;

    int  rd_cnt = 0;
    int  obs_tlps = 0;
    bit  hold_ack = 0;
    int  fixed_dly = -1;
    int  wdly = -1;
    int  cdly = -1;
    bit  prev_rd = 0;
    bit  prev_compl = 0;

    // Standard-read FIFO: data appears after the edge that samples rd_en
    always @(posedge clk) begin
        if (fifo_rd_en_o) fifo_dout_i <= popped;
    end

    // Monitor and TX-engine responder, all activity on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_wr_ack_i   = 1'b0;
            tx_cpl_done_i = 1'b0;
            wdly = -1;
            cdly = -1;
            tr = tw;
            cr = cw;
            ir = iw;
            prev_rd = 0;
            prev_compl = 0;
        end else begin
            if (fifo_rd_en_o) begin
                chk("rd_while_active", {61'd0, tx_wr_req_o, tx_cpl_req_o, cmd_compl_o}, 64'd0);
                chk("rd_pulse_width", {63'd0, prev_rd}, 64'd0);
                if (rd_ptr != wr_ptr) begin
                    popped = mem[rd_ptr % N];
                    rd_ptr++;
                end else begin
                    chk("rd_on_empty", 1, 0);
                end
                rd_cnt++;
            end
            prev_rd = fifo_rd_en_o;

            if (cmd_compl_o) begin
                chk("compl_pulse_width", {63'd0, prev_compl}, 64'd0);
                if (ir != iw) begin
                    chk("cmd_id", {62'd0, cmd_id_o}, {62'd0, e_id[ir % N]});
                    ir++;
                end else begin
                    chk("compl_unexpected", 1, 0);
                end
            end
            prev_compl = cmd_compl_o;

            if (tx_wr_ack_i) begin
                tx_wr_ack_i = 1'b0;
            end else if (tx_wr_req_o) begin
                if (!hold_ack) begin
                    if (wdly < 0) wdly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                    if (wdly == 0) begin
                        if (tr != tw) begin
                            chk("tlp_addr", {32'd0, tx_wr_addr_o}, {32'd0, e_addr[tr % N]});
                            chk("tlp_len_dw", {54'd0, tx_wr_len_dw_o}, 64'(e_dw[tr % N]));
                            chk("tlp_last", {63'd0, tx_wr_last_o}, {63'd0, e_last[tr % N]});
                            tr++;
                        end else begin
                            chk("tlp_unexpected", 1, 0);
                        end
                        obs_tlps++;
                        tx_wr_ack_i = 1'b1;
                        wdly = -1;
                    end else begin
                        wdly--;
                    end
                end
            end else if (!hold_ack && $urandom_range(0, 7) == 0) begin
                tx_wr_ack_i = 1'b1;
            end

            if (tx_cpl_done_i) begin
                tx_cpl_done_i = 1'b0;
            end else if (tx_cpl_req_o) begin
                if (cdly < 0) cdly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                if (cdly == 0) begin
                    if (cr != cw) begin
                        chk("cpl_with_data", {63'd0, tx_cpl_with_data_o}, {63'd0, e_cwd[cr % N]});
                        chk("cpl_fields", {9'd0, tx_cpl_fields_o}, {9'd0, e_cf[cr % N]});
                        cr++;
                    end else begin
                        chk("cpl_unexpected", 1, 0);
                    end
                    tx_cpl_done_i = 1'b1;
                    cdly = -1;
                end else begin
                    cdly--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                tx_cpl_done_i = 1'b1;
            end
        end
    end

    // Push one entry and record what the TX engine should see for it
    task automatic push_entry(input logic [1:0] ty, input logic [4:0] len,
                              input logic [1:0] id, input logic [54:0] pl);
        longint ad, rem, c, d;
        int l;
        mem[wr_ptr % N] = {$urandom, $urandom, ty, len, id, pl};
        if (ty == 2'b00 || ty == 2'b01) begin
            e_cwd[cw % N] = (ty == 2'b01);
            e_cf[cw % N]  = pl;
            cw++;
        end else if (ty == 2'b10) begin
            l = int'(len);
            if (l < 2) l = 2;
            if (l > 12) l = 12;
            rem = longint'(1) << l;
            ad  = longint'(pl[31:0]) & ~longint'(3);
            while (rem > 0) begin
                c = rem;
                if (c > MPS) c = MPS;
                d = 4096 - (ad % 4096);
                if (c > d) c = d;
                e_addr[tw % N] = ad[31:0];
                e_dw[tw % N]   = int'(c / 4);
                e_last[tw % N] = (c == rem);
                tw++;
                ad  = ad + c;
                rem = rem - c;
            end
            e_id[iw % N] = id;
            iw++;
        end
        wr_ptr++;
    endtask

    task automatic push_wr(input logic [4:0] len, input logic [1:0] id, input logic [31:0] addr);
        push_entry(2'b10, len, id, {23'd0, addr});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (wr_ptr == rd_ptr && !busy_o) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) chk("drain_timeout", 1, 0);
    endtask

    int base;
    int n;
    logic [31:0] r;
    logic [31:0] a;
    logic [63:0] r64;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctl", {56'd0, fifo_rd_en_o, tx_cpl_req_o, tx_cpl_with_data_o, tx_wr_req_o,
                        tx_wr_last_o, cmd_compl_o, busy_o, 1'b0}, 64'd0);
        chk("rst_fields", {9'd0, tx_cpl_fields_o}, 64'd0);
        chk("rst_wr", {20'd0, tx_wr_addr_o, tx_wr_len_dw_o, cmd_id_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single plain completion
        base = rd_cnt;
        push_entry(2'b00, 5'd6, 2'd0, 55'h12_3456_789A_BCDE);
        wait_drain(200);
        chk("cpl_pops", 64'(rd_cnt - base), 64'd1);
        chk("cpl_seen", 64'(cr), 64'(cw));

        // 512 B at an aligned address: four 32 DW TLPs
        base = obs_tlps;
        push_wr(5'd9, 2'd2, 32'h1000_0000);
        wait_drain(300);
        chk("wr512_tlps", 64'(obs_tlps - base), 64'd4);

        // 256 B straddling a 4 KB boundary: 16, 32, 16 DW
        base = obs_tlps;
        push_wr(5'd8, 2'd1, 32'h0000_0FC0);
        wait_drain(300);
        chk("wr4k_tlps", 64'(obs_tlps - base), 64'd3);

        // len clamping both ways and a dropped invalid entry
        base = obs_tlps;
        push_wr(5'd1, 2'd3, 32'h0000_0041);
        wait_drain(200);
        chk("len_low_tlps", 64'(obs_tlps - base), 64'd1);
        base = obs_tlps;
        push_wr(5'd20, 2'd0, 32'h3000_0000);
        wait_drain(2000);
        chk("len_high_tlps", 64'(obs_tlps - base), 64'd32);
        base = rd_cnt;
        push_entry(2'b11, 5'd9, 2'd2, 55'h0);
        wait_drain(200);
        chk("inv_pops", 64'(rd_cnt - base), 64'd1);
        chk("inv_busy", {63'd0, busy_o}, 64'd0);

        // Two queued writes with slow acks complete strictly in order
        fixed_dly = 5;
        base = ir;
        push_wr(5'd8, 2'd0, 32'h4000_0000);
        push_wr(5'd8, 2'd1, 32'h4000_0F80);
        wait_drain(600);
        chk("b2b_compls", 64'(ir - base), 64'd2);
        fixed_dly = -1;

        // Reset while the second TLP of a command is pending
        base = obs_tlps;
        push_wr(5'd9, 2'd3, 32'h2000_0000);
        n = 0;
        while (obs_tlps < base + 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        hold_ack = 1;
        n = 0;
        while (!tx_wr_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_req", {63'd0, tx_wr_req_o}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctl", {56'd0, fifo_rd_en_o, tx_cpl_req_o, tx_cpl_with_data_o, tx_wr_req_o,
                            tx_wr_last_o, cmd_compl_o, busy_o, 1'b0}, 64'd0);
        chk("rst_mid_wr", {20'd0, tx_wr_addr_o, tx_wr_len_dw_o, cmd_id_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_ack = 0;
        @(negedge clk);
        base = ir;
        push_wr(5'd7, 2'd2, 32'h5000_0000);
        wait_drain(300);
        chk("post_rst_compl", 64'(ir - base), 64'd1);

        // Random mix of entries, sometimes queued back to back
        for (int k = 0; k < 40; k++) begin
            r = $urandom;
            a = $urandom;
            if (r[0]) a[11:0] = 12'(4096 - 4 * int'($urandom_range(1, 40)));
            r64 = {$urandom, $urandom};
            if (r[3:2] == 2'b10 || r[3:2] == 2'b11 && r[4])
                push_wr(r[9:5], r[11:10], a);
            else
                push_entry(r[3:2], r[9:5], r[11:10], r64[54:0]);
            if (r[15:14] != 2'b00) wait_drain(4000);
        end
        wait_drain(8000);

        chk("tlps_left", 64'(tw - tr), 64'd0);
        chk("cpls_left", 64'(cw - cr), 64'd0);
        chk("compls_left", 64'(iw - ir), 64'd0);
        chk("total_pops", 64'(rd_cnt), 64'(wr_ptr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/us_cmd_sched.md
Name: us_cmd_sched

Overview:
- Upstream command scheduler; sits between the upstream command FIFO, which the inbound FSM fills, and the TX engine.
- Pops one 128-bit FIFO entry at a time and dispatches it:
  - CPL/CPLD: one completion request.
  - WR32: a sequence of posted memory-write TLP requests covering 2^len bytes, split at MAX_PAYLOAD and 4 KB boundaries.
- On WR32 finish, reports back to the inbound FSM via cmd_compl_o/cmd_id_o.

Parameters:
- MAX_PAYLOAD_BYTES, 128, maximum write TLP payload in bytes; power of two, 128..512.
- LEN_MIN, 2, smallest accepted len exponent (4 B).
- LEN_MAX, 12, largest accepted len exponent (4 KB).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fifo_empty_i  in  1  upstream command FIFO empty
- fifo_dout_i  in  128  FIFO read data; valid 1 cycle after fifo_rd_en_o (standard read mode)
- fifo_rd_en_o  out  1  FIFO pop, single-cycle pulse
- tx_cpl_req_o  out  1  completion request, level-held until done
- tx_cpl_with_data_o  out  1  1 = CplD, 0 = Cpl; valid with tx_cpl_req_o
- tx_cpl_fields_o  out  55  {tc,td,ep,attr,len,rid,tag,be,addr[7:0]}, copied from entry [54:0]
- tx_cpl_done_i  in  1  TX engine accepted the completion
- tx_wr_req_o  out  1  write-TLP request, level-held until ack
- tx_wr_addr_o  out  32  DW-aligned host address of the current TLP
- tx_wr_len_dw_o  out  10  payload length in DW of the current TLP
- tx_wr_last_o  out  1  current TLP is the final one of the command
- tx_wr_ack_i  in  1  TX engine finished sending the current TLP
- cmd_compl_o  out  1  single-cycle pulse, WR32 command finished
- cmd_id_o  out  2  command id; valid with cmd_compl_o
- busy_o  out  1  state != IDLE

Behaviour:
- Reset:
  - rst_n is synchronous, active-low; clock is clk.
  - All outputs reset to 0; state goes to IDLE. Reset mid-operation abandons the entry with no cmd_compl_o pulse.
- Entry decode:
  - [63:62] type: 00 CPL, 01 CPLD, 10 WR32, 11 invalid.
  - [61:57] len, [56:55] cmd_id, [54:0] payload. WR32 address = [31:0] with bits [1:0] forced to 0.
- State machine:
  - IDLE: if !fifo_empty_i, assert fifo_rd_en_o for 1 cycle and go to FETCH.
  - FETCH: wait 1 cycle, go to LATCH.
  - LATCH: register the entry, then branch on type.
    - CPL/CPLD -> CPL_REQ.
    - WR32 -> WR_CALC.
    - Invalid -> IDLE (entry dropped silently).
  - CPL_REQ: hold tx_cpl_req_o; on tx_cpl_done_i, deassert and go to IDLE. No cmd_compl_o.
  - WR_CALC (1 cycle): compute the chunk.
    - chunk = min(remaining, MAX_PAYLOAD_BYTES, 4096 - addr[11:0]).
    - Register tx_wr_addr_o, tx_wr_len_dw_o = chunk/4, tx_wr_last_o = (chunk == remaining).
    - Go to WR_REQ.
  - WR_REQ: hold tx_wr_req_o until tx_wr_ack_i.
    - On ack: addr += chunk, remaining -= chunk.
    - If last, go to DONE; otherwise go to WR_CALC.
  - DONE: pulse cmd_compl_o with cmd_id_o = latched id; go to IDLE.
- len rules:
  - remaining = 1 << clamp(len, LEN_MIN, LEN_MAX), held in 13 bits.
  - len below LEN_MIN is treated as LEN_MIN; len above LEN_MAX is treated as LEN_MAX.
- tx_wr_len_dw_o for a full 4 KB chunk cannot occur, because chunk <= MAX_PAYLOAD_BYTES.
- Request/ack timing:
  - Req is asserted the cycle after entering the request state.
  - Ack in the same cycle as req is accepted.
  - Ack while req is low is ignored.
- Minimum command latency: pop -> first request in 3 cycles (IDLE, FETCH, LATCH, then WR_CALC or CPL_REQ).
- Back-to-back: after DONE or a completion, IDLE pops on the next cycle if the FIFO is non-empty. Only one entry is in flight.
- Address wrap beyond 32 bits is not detected; chunking at 4 KB keeps each TLP legal.

Decomposition:
- Shared package, also used by the inbound FSM:
  - US_CMD_* type codes.
  - Entry field bit positions and the 55-bit completion-field layout.
  - LEN_MIN/LEN_MAX constants.
- One natural sub-module: us_wr_chunker, a combinational min-of-three chunk calculator (remaining, MPS, 4 KB distance) producing chunk bytes and last.

Test Plan:
- CPL entry {00, len 6, id 0, fields F} -> one fifo_rd_en_o pulse; tx_cpl_req_o=1, tx_cpl_with_data_o=0, fields=F until done; no cmd_compl_o.
- WR32 len 9, addr 0x1000_0000, MPS 128 -> 4 TLPs at 0x...000/080/100/180, 32 DW each, last on the 4th; then cmd_compl_o pulse with id.
- WR32 len 8, addr 0x0000_0FC0 -> TLPs 0xFC0 (16 DW), 0x1000 (32 DW), 0x1080 (16 DW, last): 4 KB split.
- len 1 -> one 1 DW TLP; len 20 -> 4096 B as 32 TLPs of 128 B; invalid type 11 -> popped, no TX request, busy_o drops.
- Two WR32 entries with ids 0 and 1 queued, ack delayed 5 cycles -> strictly sequential; cmd_compl_o ids 0 then 1; FIFO read only when IDLE.
- rst_n low during WR_REQ of TLP 2 -> next cycle all outputs 0, no cmd_compl_o; a fresh entry after reset processes normally.
